sipo_nibble_loader: RTL and testbench

- Upstream stage of the 4-bit tri-state holding register.
- Assembles a serial bit stream into a WIDTH-bit word with optional parity check.
- Drives the register's data, level-enable, clear and output-enable inputs, so a word is captured only when it is complete and stable.
- Sits between the serial input pins and the register on the shared nibble bus.

---
 rtl/sipo_nibble_loader_pkg.sv | 16 +
 rtl/sipo_nibble_loader_if.sv | 27 ++
 rtl/sipo_nibble_loader_shift_core.sv | 54 +++++
 rtl/sipo_nibble_loader.sv | 113 +++++++++++
 tb/tb_sipo_nibble_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_nibble_loader_pkg.sv
// Shared definitions for the serial-to-nibble loader and its downstream holding register.
// No logic; the state encoding and the default nibble width live here.
package sipo_nibble_loader_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PAR    = 3'd2,
    LOAD   = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

endpackage

// File: rtl/sipo_nibble_loader_if.sv
// Serial input pins plus register-side drive of the shared nibble bus.
// Pure wiring; slave is the loader's view, master is the stimulus side.
interface sipo_nibble_loader_if import sipo_nibble_loader_pkg::*; #(
  parameter int WIDTH = NIBBLE_W
);
  logic             start;
  logic             sdi;
  logic             sdi_en;
  logic             flush;
  logic [WIDTH-1:0] reg_d;
  logic             reg_clk;
  logic             reg_clr;
  logic             reg_oe;
  logic             busy;
  logic             done;
  logic             par_err;

  modport master (
    output start, sdi, sdi_en, flush,
    input  reg_d, reg_clk, reg_clr, reg_oe, busy, done, par_err
  );

  modport slave (
    input  start, sdi, sdi_en, flush,
    output reg_d, reg_clk, reg_clr, reg_oe, busy, done, par_err
  );
endinterface

// File: rtl/sipo_nibble_loader_shift_core.sv
// Shift register, bit counter and running data parity; one bit per shift_en, updated on the
// clock edge. No backpressure: the caller only pulses shift_en while a frame is open.
module sipo_shift_core import sipo_nibble_loader_pkg::*; #(
  parameter int WIDTH     = NIBBLE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             frame_clr,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] word,
  output logic             last_bit,
  output logic             parity
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    par_d = par_q;
    if (frame_clr) begin
      sr_d  = '0;
      cnt_d = '0;
      par_d = 1'b0;
    end else if (shift_en) begin
      // LSB-first enters at the top so the first bit has walked down to bit 0 after WIDTH shifts
      sr_d  = LSB_FIRST ? {sdi, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sdi};
      cnt_d = cnt_q + CNT_W'(1);
      par_d = par_q ^ sdi;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      par_q <= par_d;
    end
  end

  assign word     = sr_q;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign parity   = par_q;

endmodule

// File: rtl/sipo_nibble_loader.sv
// Frames serial bits into a word and strobes it into the level-sensitive holding register.
// reg_d after N+1, reg_clk after N+2, done after N+3 (N = last accepted bit); sdi_en=0 stalls.
module sipo_nibble_loader import sipo_nibble_loader_pkg::*; #(
  parameter int WIDTH     = NIBBLE_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  sipo_nibble_loader_if.slave  bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             reg_clk_q, reg_clk_d;
  logic             reg_clr_q, reg_clr_d;
  logic             reg_oe_q;
  logic             done_q, done_d;
  logic             par_err_q, par_err_d;
  logic             frame_clr, shift_en;
  logic [WIDTH-1:0] word;
  logic             last_bit, parity;

  sipo_shift_core #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_core (
    .clk      (clk),
    .clr_n    (clr_n),
    .frame_clr(frame_clr),
    .shift_en (shift_en),
    .sdi      (bus.sdi),
    .word     (word),
    .last_bit (last_bit),
    .parity   (parity)
  );

  always_comb begin
    state_d   = state_q;
    reg_d_d   = reg_d_q;
    reg_clk_d = 1'b0;
    reg_clr_d = 1'b0;
    done_d    = 1'b0;
    par_err_d = 1'b0;
    frame_clr = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          frame_clr = 1'b1;
          state_d   = SHIFT;
        end else if (bus.flush) begin
          reg_clr_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.sdi_en) begin
          shift_en = 1'b1;
          if (last_bit) state_d = PARITY_EN ? PAR : LOAD;
        end
      end
      PAR: begin
        if (bus.sdi_en) begin
          if (parity ^ bus.sdi) begin
            par_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      // Outputs are registered, so each one lands a cycle after the state that requests it
      LOAD: begin
        reg_d_d = word;
        state_d = STROBE;
      end
      STROBE: begin
        reg_clk_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      reg_d_q   <= '0;
      reg_clk_q <= 1'b0;
      reg_clr_q <= 1'b1;
      reg_oe_q  <= 1'b1;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_d_q   <= reg_d_d;
      reg_clk_q <= reg_clk_d;
      reg_clr_q <= reg_clr_d;
      reg_oe_q  <= 1'b0;
      done_q    <= done_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.reg_d   = reg_d_q;
  assign bus.reg_clk = reg_clk_q;
  assign bus.reg_clr = reg_clr_q;
  assign bus.reg_oe  = reg_oe_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.par_err = par_err_q;

endmodule

// File: tb/tb_sipo_nibble_loader.sv
// Bench for sipo_nibble_loader: LSB-first/parity instance checked through a scoreboard and a
// modelled holding register, plus an MSB-first/no-parity instance driven with directed frames.
module tb_sipo_nibble_loader;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  sipo_nibble_loader_if #(.WIDTH(4)) ifa();
  sipo_nibble_loader_if #(.WIDTH(4)) ifb();

  sipo_nibble_loader #(.WIDTH(4), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_dut_a (
    .clk(clk), .clr_n(clr_n), .bus(ifa)
  );
  sipo_nibble_loader #(.WIDTH(4), .LSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .bus(ifb)
  );

  typedef struct packed {
    logic       err;
    logic [3:0] word;
  } sb_t;

  typedef struct {
    logic [4:0] bits;   // bits[0] is sent first, bits[4] is the parity bit
    logic [3:0] w;
    bit         err;
  } vec_t;

  int         total  = 0;
  int         passed = 0;
  sb_t        sb[$];
  logic [3:0] model_a   = 4'h0;
  logic [3:0] prev_d    = 4'h0;
  logic [3:0] exp_reg_a = 4'h0;
  int         clk_run   = 0;
  int         pulses    = 0;
  int         events    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Holding-register model and scoreboard consumer for instance A
  always @(negedge clk) begin
    sb_t e;
    if (!clr_n) begin
      model_a = 4'h0;
      clk_run = 0;
    end else begin
      if (ifa.reg_clr) model_a = 4'h0;
      else if (ifa.reg_clk) model_a = ifa.reg_d;
      if (ifa.reg_clk) begin
        clk_run++;
        chk("reg_d_stable_while_clk", ifa.reg_d, prev_d);
      end else if (clk_run != 0) begin
        chk("reg_clk_width", clk_run, 1);
        clk_run = 0;
        pulses++;
      end
      if (ifa.done) begin
        events++;
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_kind", e.err, 0);
          chk("done_reg_d", ifa.reg_d, e.word);
          chk("done_model_reg", model_a, e.word);
        end
      end
      if (ifa.par_err) begin
        events++;
        chk("perr_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("perr_kind", e.err, 1);
          chk("perr_reg_d_kept", ifa.reg_d, e.word);
        end
      end
    end
    prev_d = ifa.reg_d;
  end

  task automatic cyc_a(input logic s, input logic d, input logic e, input logic f);
    ifa.start = s; ifa.sdi = d; ifa.sdi_en = e; ifa.flush = f;
    @(posedge clk); #1;
    ifa.start = 1'b0; ifa.sdi = 1'b0; ifa.sdi_en = 1'b0; ifa.flush = 1'b0;
  endtask

  task automatic cyc_b(input logic s, input logic d, input logic e);
    ifb.start = s; ifb.sdi = d; ifb.sdi_en = e;
    @(posedge clk); #1;
    ifb.start = 1'b0; ifb.sdi = 1'b0; ifb.sdi_en = 1'b0;
  endtask

  task automatic send_a(input logic [4:0] bits, input logic [3:0] w, input bit err,
                        input bit gaps, input bit fl);
    int  ev0;
    sb_t e;
    ev0    = events;
    e.err  = err;
    e.word = err ? exp_reg_a : w;
    sb.push_back(e);
    if (!err) exp_reg_a = w;
    cyc_a(1'b1, 1'b0, 1'b0, fl);
    if (fl) begin
      chk("flush_with_start_clr", ifa.reg_clr, 0);
      chk("flush_with_start_busy", ifa.busy, 1);
    end
    for (int i = 0; i < 5; i++) begin
      // gap cycles carry a stray start and random sdi, both of which must be ignored
      if (gaps) cyc_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cyc_a(1'b0, bits[i], 1'b1, 1'b0);
    end
    for (int k = 0; k < 10 && events == ev0; k++) @(posedge clk);
    chk("frame_complete", events != ev0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [3:0] bits, input logic [3:0] w);
    bit seen;
    seen = 1'b0;
    cyc_b(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc_b(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      cyc_b(1'b0, bits[i], 1'b1);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (ifb.done) seen = 1'b1;
    end
    chk("b_done_seen", seen, 1);
    chk("b_reg_d", ifb.reg_d, w);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[6];
    logic [4:0] bits;
    int         ev0;
    int         p0;

    tbl[0] = '{5'b10001, 4'h1, 1'b0};
    tbl[1] = '{5'b00000, 4'h0, 1'b0};
    tbl[2] = '{5'b11111, 4'hF, 1'b1};
    tbl[3] = '{5'b01010, 4'hA, 1'b0};
    tbl[4] = '{5'b11011, 4'hB, 1'b0};
    tbl[5] = '{5'b00111, 4'h7, 1'b1};

    ifa.start = 1'b0; ifa.sdi = 1'b0; ifa.sdi_en = 1'b0; ifa.flush = 1'b0;
    ifb.start = 1'b0; ifb.sdi = 1'b0; ifb.sdi_en = 1'b0; ifb.flush = 1'b0;

    // Reset values, then release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_clr", ifa.reg_clr, 1);
    chk("rst_reg_oe", ifa.reg_oe, 1);
    chk("rst_reg_clk", ifa.reg_clk, 0);
    chk("rst_reg_d", ifa.reg_d, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_par_err", ifa.par_err, 0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("rel_oe_before_edge", ifa.reg_oe, 1);
    @(posedge clk); #1;
    chk("rel_reg_clr", ifa.reg_clr, 0);
    chk("rel_reg_oe", ifa.reg_oe, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_reg_d", ifa.reg_d, 0);
    chk("idle_busy", ifa.busy, 0);

    // Frame 1,0,1,1 + parity 1 with cycle-exact latency
    begin
      sb_t e;
      e.err = 1'b0; e.word = 4'hD;
      sb.push_back(e);
      exp_reg_a = 4'hD;
    end
    bits = 5'b11101;
    cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_in_frame", ifa.busy, 1);
    for (int i = 0; i < 5; i++) cyc_a(1'b0, bits[i], 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_n_reg_d_old", ifa.reg_d, 0);
    @(negedge clk);
    chk("lat_n1_reg_d", ifa.reg_d, 4'hD);
    chk("lat_n1_reg_clk", ifa.reg_clk, 0);
    @(negedge clk);
    chk("lat_n2_reg_clk", ifa.reg_clk, 1);
    chk("lat_n2_done", ifa.done, 0);
    @(negedge clk);
    chk("lat_n3_done", ifa.done, 1);
    chk("lat_n3_reg_clk", ifa.reg_clk, 0);
    chk("lat_n3_busy", ifa.busy, 0);
    @(negedge clk);
    chk("done_one_cycle", ifa.done, 0);
    chk("model_holds_d", model_a, 4'hD);
    @(posedge clk); #1;

    // Same frame with a bad parity bit
    p0 = pulses;
    send_a(5'b01101, 4'hD, 1'b1, 1'b0, 1'b0);
    chk("perr_no_strobe", pulses, p0);
    chk("perr_busy", ifa.busy, 0);

    // Flush alone, then flush together with start
    cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_clr_high", ifa.reg_clr, 1);
    @(negedge clk);
    chk("flush_clr_one_cycle", ifa.reg_clr, 0);
    chk("flush_model_reg", model_a, 0);
    @(posedge clk); #1;
    send_a(5'b01111, 4'hF, 1'b0, 1'b0, 1'b1);

    // MSB-first, no parity, sdi_en every other cycle
    send_b(4'b1001, 4'b1001);
    send_b(4'b1011, 4'b1101);

    // Reset after two bits
    ev0 = events;
    cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
    cyc_a(1'b0, 1'b1, 1'b1, 1'b0);
    clr_n = 1'b0;
    #1;
    chk("abort_reg_clk", ifa.reg_clk, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_reg_d", ifa.reg_d, 0);
    exp_reg_a = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while reg_clk is high must drop it at once
    bits = 5'b01111;
    cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc_a(1'b0, bits[i], 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("strobe_before_rst", ifa.reg_clk, 1);
    clr_n = 1'b0;
    #1;
    chk("async_drop_reg_clk", ifa.reg_clk, 0);
    chk("async_reg_clr", ifa.reg_clr, 1);
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", events, ev0);

    send_a(5'b00110, 4'h6, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) send_a(tbl[i].bits, tbl[i].w, tbl[i].err, (i % 2) == 1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
